// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared types and register map for the interrupt controller
package intr_pkg;
  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_PEND = 2'd1;
  localparam logic [1:0] A_ISR  = 2'd2;
  localparam logic [1:0] A_EOI  = 2'd3;
endpackage

// File: rtl/intr_prio_enc.sv
// rtl/intr_prio_enc.sv - lowest-index-first priority encoder with valid flag
module intr_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);
  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - interrupt controller, request side of intr/inta; INTR_NEST_EN enables nesting
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int          NSRC     = 8,
  parameter int          IDW      = 3,
  parameter logic [31:0] VEC_BASE = 32'h0000_0008
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NSRC-1:0] irq,
  output logic            intr,
  input  logic            inta,
  output logic [IDW-1:0]  id,
  output logic [31:0]     vector,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata
);
  state_t          state, state_nx;
  logic [NSRC-1:0] irq_q, pending, mask, isr;
  logic [NSRC-1:0] eligible, rise, id_onehot, pend_clr;
  logic            win_valid, raise, ack, eoi_wr;

  assign rise      = irq & ~irq_q;
  assign eligible  = pending & ~mask;
  assign id_onehot = {{(NSRC-1){1'b0}}, 1'b1} << id;
  assign eoi_wr    = we && (addr == A_EOI);
  assign intr      = (state == REQ);
  assign vector    = VEC_BASE + (32'(id) << 2);

  intr_prio_enc #(.N(NSRC), .W(IDW)) u_arb (
    .req   (eligible),
    .idx   (id),
    .valid (win_valid)
  );

`ifdef INTR_NEST_EN
  logic [IDW-1:0]  isr_top;
  logic            isr_valid;
  logic [NSRC-1:0] isr_nx;

  intr_prio_enc #(.N(NSRC), .W(IDW)) u_lvl (
    .req   (isr),
    .idx   (isr_top),
    .valid (isr_valid)
  );

  // Only a strictly higher-priority winner may preempt the active level.
  assign raise = win_valid && (!isr_valid || (id < isr_top));

  always_comb begin
    isr_nx = isr;
    if (eoi_wr) isr_nx = isr_nx & ~({{(NSRC-1){1'b0}}, 1'b1} << isr_top);
    if (ack)    isr_nx = isr_nx | id_onehot;
  end
`else
  assign raise = win_valid;
`endif

  always_comb begin
    state_nx = state;
    ack      = 1'b0;
    case (state)
      IDLE: if (raise) state_nx = REQ;
      REQ: begin
        if (inta && raise) begin
          ack = 1'b1;
`ifdef INTR_NEST_EN
          state_nx = IDLE;
`else
          state_nx = SERV;
`endif
        end else if (!raise) begin
          state_nx = IDLE;
        end
      end
      SERV:    if (eoi_wr) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Set of a pending bit wins over a same-cycle clear.
  assign pend_clr = ((we && (addr == A_PEND)) ? wdata[NSRC-1:0] : '0)
                  | (ack ? id_onehot : '0);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      irq_q   <= '0;
      pending <= '0;
      mask    <= '1;
      isr     <= '0;
    end else begin
      state   <= state_nx;
      irq_q   <= irq;
      pending <= (pending & ~pend_clr) | rise;
      if (we && (addr == A_MASK)) mask <= wdata[NSRC-1:0];
`ifdef INTR_NEST_EN
      isr <= isr_nx;
`else
      if (ack)         isr <= id_onehot;
      else if (eoi_wr) isr <= '0;
`endif
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      A_MASK:  rdata[NSRC-1:0] = mask;
      A_PEND:  rdata[NSRC-1:0] = pending;
      A_ISR:   rdata[NSRC-1:0] = isr;
      default: rdata = '0;
    endcase
  end

  generate
    if (NSRC < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^wdata[31:NSRC];
    end
  endgenerate
endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - scoreboard bench for intr_ctrl
module tb_intr_ctrl;
  import intr_pkg::*;

  localparam int          K_INTR = 0, K_ID = 1, K_VEC = 2, K_RD = 3;
  localparam logic [31:0] VBASE  = 32'h0000_0008;

  logic        clk = 1'b0, clr = 1'b1, inta = 1'b0, we = 1'b0;
  logic [7:0]  irq = '0;
  logic [1:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        intr;
  logic [2:0]  id;
  logic [31:0] vector, rdata;

  logic probe = 1'b0;
  int   tests = 0, fails = 0;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;
  exp_t exp_q[$];
  int   ack_q[$];

  intr_ctrl #(.NSRC(8), .IDW(3), .VEC_BASE(VBASE)) dut (
    .clk(clk), .clr(clr), .irq(irq), .intr(intr), .inta(inta), .id(id),
    .vector(vector), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic cmp(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h expected=%h", n, act, exp);
    end
  endtask

  // Monitor: drains expectations when probed, and checks every accepted handshake.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    int          x;
    if (probe) begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.kind)
          K_INTR:  act = {31'b0, intr};
          K_ID:    act = {29'b0, id};
          K_VEC:   act = vector;
          default: act = rdata;
        endcase
        cmp(e.name, act, e.val);
      end
    end
    if (intr && inta) begin
      if (ack_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: actual id=%0d expected no acknowledge", id);
      end else begin
        x = ack_q.pop_front();
        cmp("ack_id", {29'b0, id}, 32'(x));
        cmp("ack_vector", vector, VBASE + (32'(x) << 2));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(int k, logic [31:0] v, string n);
    exp_t e;
    e.kind = k; e.val = v; e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    probe = 1'b1;
    @(negedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic rd(logic [1:0] a, logic [31:0] v, string n);
    addr = a;
    chk(K_RD, v, n);
    sample();
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic ack(int exp_id);
    cyc();
    inta = 1'b1;
    ack_q.push_back(exp_id);
    cyc();
    inta = 1'b0;
  endtask

  initial begin
    repeat (2) cyc();
    chk(K_INTR, 0, "rst_intr"); chk(K_ID, 0, "rst_id"); chk(K_VEC, VBASE, "rst_vector");
    rd(A_MASK, 32'hFF, "rst_mask");
    rd(A_PEND, 0, "rst_pend");
    rd(A_ISR, 0, "rst_isr");
    clr = 1'b0;
    cyc();

    // Basic flow on source 2
    wr(A_MASK, 32'hF0);
    irq = 8'h04; cyc(); irq = 8'h00;
    chk(K_INTR, 0, "edge_intr_low");
    rd(A_PEND, 32'h04, "basic_pend");
    cyc();
    chk(K_INTR, 1, "basic_intr"); chk(K_ID, 2, "basic_id"); chk(K_VEC, 32'h10, "basic_vector");
    sample();
    ack(2);
    chk(K_INTR, 0, "basic_serv_intr");
    rd(A_ISR, 32'h04, "basic_isr");
    rd(A_PEND, 0, "basic_pend_clr");
    wr(A_EOI, 32'h0);
    chk(K_INTR, 0, "eoi_intr");
    rd(A_ISR, 0, "eoi_isr");

    // Priority: sources 3 and 1 together
    irq = 8'h0A; cyc(); irq = 8'h00; cyc();
    chk(K_INTR, 1, "prio_intr"); chk(K_ID, 1, "prio_id");
    sample();
    ack(1);
    chk(K_INTR, 0, "prio_serv_intr");
    rd(A_PEND, 32'h08, "prio_pend");
    cyc(); cyc();
    chk(K_INTR, 0, "prio_serv_hold");
    sample();
    wr(A_EOI, 32'h0);
    cyc();
    chk(K_INTR, 1, "prio_reassert"); chk(K_ID, 3, "prio_id3"); chk(K_VEC, 32'h14, "prio_vector3");
    sample();
    ack(3);
    wr(A_EOI, 32'h0);

    // Re-arbitration while in REQ
    irq = 8'h08; cyc(); irq = 8'h00; cyc();
    chk(K_INTR, 1, "rearb_intr"); chk(K_ID, 3, "rearb_id3");
    sample();
    irq = 8'h01; cyc(); irq = 8'h00;
    chk(K_INTR, 1, "rearb_intr_hold"); chk(K_ID, 0, "rearb_id0"); chk(K_VEC, VBASE, "rearb_vector0");
    sample();
    ack(0);
    rd(A_PEND, 32'h08, "rearb_pend");
    rd(A_ISR, 32'h01, "rearb_isr");
    wr(A_EOI, 32'h0);
    cyc();
    chk(K_INTR, 1, "rearb_pend_req"); chk(K_ID, 3, "rearb_pend_id");
    sample();

    // Withdraw by masking
    wr(A_MASK, 32'hFF);
    cyc();
    chk(K_INTR, 0, "withdraw_intr");
    rd(A_PEND, 32'h08, "withdraw_pend");

    // inta while idle is ignored
    cyc(); inta = 1'b1; cyc(); inta = 1'b0;
    chk(K_INTR, 0, "idle_inta_intr");
    rd(A_PEND, 32'h08, "idle_inta_pend");
    rd(A_ISR, 0, "idle_inta_isr");

    // Held request does not re-pend after clear
    wr(A_PEND, 32'hFF);
    irq = 8'h04; cyc();
    rd(A_PEND, 32'h04, "hold_pend_set");
    wr(A_PEND, 32'h04);
    cyc(); cyc();
    rd(A_PEND, 0, "hold_no_repend");
    irq = 8'h00; cyc();

    // Nesting sequence: source 3 in service, then source 1 arrives
    wr(A_MASK, 32'hF0);
    irq = 8'h08; cyc(); irq = 8'h00; cyc();
    ack(3);
    irq = 8'h02; cyc(); irq = 8'h00; cyc();
`ifdef INTR_NEST_EN
    chk(K_INTR, 1, "nest_intr"); chk(K_ID, 1, "nest_id");
    sample();
    ack(1);
    rd(A_ISR, 32'h0A, "nest_isr_both");
    wr(A_EOI, 32'h0);
    rd(A_ISR, 32'h08, "nest_eoi_lowest");
    wr(A_EOI, 32'h0);
    rd(A_ISR, 0, "nest_eoi_last");
`else
    chk(K_INTR, 0, "nonest_hold");
    rd(A_ISR, 32'h08, "nonest_isr");
    wr(A_EOI, 32'h0);
    cyc();
    chk(K_INTR, 1, "nonest_after_eoi"); chk(K_ID, 1, "nonest_id");
    sample();
    ack(1);
    rd(A_ISR, 32'h02, "nonest_isr1");
    wr(A_EOI, 32'h0);
    rd(A_ISR, 0, "nonest_eoi");
`endif

    // Rising edge and PEND clear in the same cycle: set wins
    irq = 8'h02; we = 1'b1; addr = A_PEND; wdata = 32'hFF;
    cyc();
    we = 1'b0; irq = 8'h00;
    rd(A_PEND, 32'h02, "set_wins");
    cyc();
    chk(K_INTR, 1, "set_wins_intr"); chk(K_ID, 1, "set_wins_id");
    sample();

    // Reset mid-handshake drops the in-flight acknowledge
    clr = 1'b1; inta = 1'b1;
    cyc();
    inta = 1'b0;
    chk(K_INTR, 0, "clr_intr");
    rd(A_PEND, 0, "clr_pend");
    rd(A_MASK, 32'hFF, "clr_mask");
    clr = 1'b0;
    cyc();
    chk(K_INTR, 0, "clr_after_intr");
    rd(A_ISR, 0, "clr_isr");

    cyc();
    cmp("exp_q_drained", 32'(exp_q.size()), 0);
    cmp("ack_q_drained", 32'(ack_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
